mipi_csi_packet_parser: RTL and testbench
=========================================

// Module: mipi_csi_packet_parser
// PURPOSE
//  Single-lane MIPI CSI-2 packet parser directly downstream of the byte-alignment stage.
//  Takes aligned, locked byte stream; finds SoT sync byte, decodes 4-byte packet header,
//  checks ECC; emits frame/line sync pulses and long-packet payload bytes; checks payload CRC-16.
//  After every packet (or abort) drives the re-search request back to the aligner for next burst.
// PARAMETERS
//  MAX_WC     16'd4096  largest accepted long-packet word count; larger WC -> packet rejected
//  SOT_BYTE   8'hB8     sync byte that precedes the packet header
// PORTS
//  I_CLK               in   1   byte clock (same domain as aligner)
//  I_Rst_n             in   1   reset; one clock; asynchronous, active-low
//  I_Byte_Data         in   8   aligned byte from aligner
//  I_Byte_Valid        in   1   aligner locked; bytes meaningful only while high
//  O_ReSearch_Offset   out  1   request aligner re-search (level; rising edge is the request)
//  O_Frame_Start       out  1   1-cycle pulse, FS short packet (DT 0x00) accepted
//  O_Frame_End         out  1   1-cycle pulse, FE (DT 0x01)
//  O_Line_Start        out  1   1-cycle pulse, LS (DT 0x02)
//  O_Line_End          out  1   1-cycle pulse, LE (DT 0x03)
//  O_Pix_Data          out  8   payload byte of long packet
//  O_Pix_Valid         out  1   O_Pix_Data qualifier
//  O_Data_Type         out  6   DT of current/last packet (held until next header)
//  O_VC                out  2   virtual channel of current/last packet
//  O_Word_Count        out  16  WC of current/last packet (short: data field)
//  O_Pkt_Done          out  1   1-cycle pulse, long packet completed (CRC bytes consumed)
//  O_Ecc_Err           out  1   1-cycle pulse, header ECC mismatch
//  O_Crc_Err           out  1   1-cycle pulse with O_Pkt_Done when payload CRC mismatches
//  O_Abort             out  1   1-cycle pulse, I_Byte_Valid dropped mid-packet or WC > MAX_WC
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters and CRC register cleared.
//  States: IDLE -> HDR -> (PAYLOAD -> CRC) -> RESYNC -> IDLE.
//  IDLE: wait I_Byte_Valid=1 and I_Byte_Data==SOT_BYTE; SoT byte consumed -> HDR, hdr_cnt=0.
//   Valid bytes != SOT_BYTE in IDLE ignored.
//  HDR: capture 4 bytes in order DI, WC[7:0], WC[15:8], ECC. VC=DI[7:6], DT=DI[5:0].
//   ECC = CSI-2 6-bit Hamming over 24 header bits (parity bits P5..P0, ECC[7:6] must be 0).
//   On 4th byte: O_Data_Type/O_VC/O_Word_Count updated same edge.
//   Mismatch -> O_Ecc_Err pulse, no sync/payload output, -> RESYNC (no correction attempted).
//   DT 0x00..0x0F: short; matching sync pulse (0x00..0x03) 1 cycle after ECC byte; others silent; -> RESYNC.
//   DT >= 0x10: long; WC==0 -> CRC directly; WC > MAX_WC -> O_Abort, RESYNC; else PAYLOAD.
//  PAYLOAD: each valid byte -> O_Pix_Data/O_Pix_Valid registered, latency 1 cycle; byte counter
//   16-bit, counts to WC; CRC-16 (poly x^16+x^12+x^5+1, init 16'hFFFF, LSB-first, reflected)
//   updated per byte. Last payload byte -> CRC.
//  CRC: 2 bytes, LSB first. After MSB: O_Pkt_Done pulse; O_Crc_Err=1 same cycle if received != computed.
//   Payload already emitted is not retracted on CRC error.
//  RESYNC: O_ReSearch_Offset=1 from entry until I_Byte_Valid sampled 0, then 0 and -> IDLE.
//   If I_Byte_Valid already 0 at entry: asserted exactly one cycle, then IDLE.
//  Abort: I_Byte_Valid=0 in HDR/PAYLOAD/CRC -> O_Abort pulse, O_Pix_Valid forced 0, -> RESYNC.
//  Simultaneous: abort has priority over ECC/CRC evaluation in the same cycle; no Pkt_Done on abort.
//  Pulses never overlap except O_Pkt_Done+O_Crc_Err. Async reset mid-packet: immediate IDLE, all outputs 0.
// TESTING
//  FS: valid=1, bytes B8,00,00,00,00 -> O_Frame_Start pulse 1 cycle after last, VC=0,WC=0; then O_ReSearch_Offset
//   rises, falls cycle after valid drops.
//  RAW8 long: B8, DI=0x2A, WC=4 (04,00), correct ECC, payload 11 22 33 44, correct CRC -> 4 O_Pix_Valid beats
//   11..44 each 1 cycle after input, O_Pkt_Done=1, O_Crc_Err=0, O_Word_Count=4.
//  Same packet, CRC LSB flipped -> O_Pkt_Done=1 with O_Crc_Err=1; 4 bytes still output.
//  FE header with ECC bit0 flipped -> O_Ecc_Err pulse, no O_Frame_End, re-search requested.
//  Long WC=100, valid drops after 10 payload bytes -> 10 pix beats, O_Abort pulse, no O_Pkt_Done, back to IDLE.
//  WC=MAX_WC+1 -> O_Abort after ECC byte, zero pix beats; async reset mid-payload -> all outputs 0 next edge.

Source files
------------

// File: rtl/mipi_csi_packet_parser.sv
// mipi_csi_packet_parser
//   Single-lane CSI-2 packet parser fed by the byte aligner. Finds the SoT byte,
//   decodes and ECC-checks the 4-byte header, emits frame/line sync pulses and
//   long-packet payload bytes, checks the payload CRC-16, then asks the aligner
//   to re-search before the next burst.
// Ports
//   I_CLK, I_Rst_n         byte clock, asynchronous active-low reset
//   I_Byte_Data/_Valid     aligned byte stream; Valid low means aligner not locked
//   O_ReSearch_Offset      level request to the aligner (rising edge = request)
//   O_Frame/Line_Start/End sync pulses for DT 0x00..0x03
//   O_Pix_Data/_Valid      payload bytes, one cycle after input
//   O_Data_Type/VC/Word_Count  fields of current/last header
//   O_Pkt_Done, O_Crc_Err  end of long packet, CRC mismatch flag
//   O_Ecc_Err, O_Abort     header ECC mismatch, lost lock / oversize WC
module mipi_csi_packet_parser #(
    parameter logic [15:0] MAX_WC   = 16'd4096,
    parameter logic [7:0]  SOT_BYTE = 8'hB8
) (
    input  logic        I_CLK,
    input  logic        I_Rst_n,
    input  logic [7:0]  I_Byte_Data,
    input  logic        I_Byte_Valid,
    output logic        O_ReSearch_Offset,
    output logic        O_Frame_Start,
    output logic        O_Frame_End,
    output logic        O_Line_Start,
    output logic        O_Line_End,
    output logic [7:0]  O_Pix_Data,
    output logic        O_Pix_Valid,
    output logic [5:0]  O_Data_Type,
    output logic [1:0]  O_VC,
    output logic [15:0] O_Word_Count,
    output logic        O_Pkt_Done,
    output logic        O_Ecc_Err,
    output logic        O_Crc_Err,
    output logic        O_Abort
);

    typedef enum logic [2:0] {StIdle, StHdr, StPayload, StCrc, StResync} state_e;

    state_e      state_q, state_d;
    logic [1:0]  hdr_cnt_q, hdr_cnt_d;
    logic [7:0]  di_q, di_d, wcl_q, wcl_d, wch_q, wch_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [15:0] crc_q, crc_d;
    logic [7:0]  crc_lo_q, crc_lo_d;
    logic        crc_idx_q, crc_idx_d;
    logic        research_q, research_d;
    logic        fs_q, fs_d, fe_q, fe_d, ls_q, ls_d, le_q, le_d;
    logic [7:0]  pix_data_q, pix_data_d;
    logic        pix_valid_q, pix_valid_d;
    logic [5:0]  dt_q, dt_d;
    logic [1:0]  vc_q, vc_d;
    logic [15:0] wc_q, wc_d;
    logic        done_q, done_d, ecc_err_q, ecc_err_d, crc_err_q, crc_err_d, abort_q, abort_d;

    logic [15:0] wc_hdr;
    logic [5:0]  ecc_exp;

    // CSI-2 header Hamming code; d = {WC[15:8], WC[7:0], DI}
    function automatic logic [5:0] ecc_calc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

    // Reflected CRC-16 (x^16+x^12+x^5+1), one byte, LSB first
    function automatic logic [15:0] crc_next(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

    assign wc_hdr  = {wch_q, wcl_q};
    assign ecc_exp = ecc_calc({wch_q, wcl_q, di_q});

    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        di_d        = di_q;
        wcl_d       = wcl_q;
        wch_d       = wch_q;
        byte_cnt_d  = byte_cnt_q;
        crc_d       = crc_q;
        crc_lo_d    = crc_lo_q;
        crc_idx_d   = crc_idx_q;
        research_d  = research_q;
        pix_data_d  = pix_data_q;
        dt_d        = dt_q;
        vc_d        = vc_q;
        wc_d        = wc_q;
        pix_valid_d = 1'b0;
        fs_d        = 1'b0;
        fe_d        = 1'b0;
        ls_d        = 1'b0;
        le_d        = 1'b0;
        done_d      = 1'b0;
        ecc_err_d   = 1'b0;
        crc_err_d   = 1'b0;
        abort_d     = 1'b0;

        case (state_q)
            StIdle: begin
                if (I_Byte_Valid && (I_Byte_Data == SOT_BYTE)) begin
                    state_d   = StHdr;
                    hdr_cnt_d = 2'd0;
                end
            end
            StHdr: begin
                if (!I_Byte_Valid) begin
                    abort_d = 1'b1;
                    state_d = StResync;
                end else begin
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    case (hdr_cnt_q)
                        2'd0: di_d  = I_Byte_Data;
                        2'd1: wcl_d = I_Byte_Data;
                        2'd2: wch_d = I_Byte_Data;
                        default: begin
                            dt_d = di_q[5:0];
                            vc_d = di_q[7:6];
                            wc_d = wc_hdr;
                            if (I_Byte_Data != {2'b00, ecc_exp}) begin
                                ecc_err_d = 1'b1;
                                state_d   = StResync;
                            end else if (di_q[5:4] == 2'b00) begin
                                case (di_q[5:0])
                                    6'h00:   fs_d = 1'b1;
                                    6'h01:   fe_d = 1'b1;
                                    6'h02:   ls_d = 1'b1;
                                    6'h03:   le_d = 1'b1;
                                    default: ;
                                endcase
                                state_d = StResync;
                            end else if (wc_hdr > MAX_WC) begin
                                abort_d = 1'b1;
                                state_d = StResync;
                            end else begin
                                crc_d      = 16'hFFFF;
                                byte_cnt_d = 16'd0;
                                crc_idx_d  = 1'b0;
                                state_d    = (wc_hdr == 16'd0) ? StCrc : StPayload;
                            end
                        end
                    endcase
                end
            end
            StPayload: begin
                if (!I_Byte_Valid) begin
                    abort_d = 1'b1;
                    state_d = StResync;
                end else begin
                    pix_data_d  = I_Byte_Data;
                    pix_valid_d = 1'b1;
                    crc_d       = crc_next(crc_q, I_Byte_Data);
                    byte_cnt_d  = byte_cnt_q + 16'd1;
                    if ((byte_cnt_q + 16'd1) == wc_q) begin
                        state_d   = StCrc;
                        crc_idx_d = 1'b0;
                    end
                end
            end
            StCrc: begin
                if (!I_Byte_Valid) begin
                    abort_d = 1'b1;
                    state_d = StResync;
                end else if (!crc_idx_q) begin
                    crc_lo_d  = I_Byte_Data;
                    crc_idx_d = 1'b1;
                end else begin
                    done_d    = 1'b1;
                    crc_err_d = ({I_Byte_Data, crc_lo_q} != crc_q);
                    state_d   = StResync;
                end
            end
            StResync: begin
                if (!I_Byte_Valid) begin
                    research_d = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Request is raised on the edge that enters re-sync
        if ((state_d == StResync) && (state_q != StResync)) begin
            research_d = 1'b1;
        end
    end

    always_ff @(posedge I_CLK or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            state_q     <= StIdle;
            hdr_cnt_q   <= 2'd0;
            di_q        <= 8'd0;
            wcl_q       <= 8'd0;
            wch_q       <= 8'd0;
            byte_cnt_q  <= 16'd0;
            crc_q       <= 16'd0;
            crc_lo_q    <= 8'd0;
            crc_idx_q   <= 1'b0;
            research_q  <= 1'b0;
            fs_q        <= 1'b0;
            fe_q        <= 1'b0;
            ls_q        <= 1'b0;
            le_q        <= 1'b0;
            pix_data_q  <= 8'd0;
            pix_valid_q <= 1'b0;
            dt_q        <= 6'd0;
            vc_q        <= 2'd0;
            wc_q        <= 16'd0;
            done_q      <= 1'b0;
            ecc_err_q   <= 1'b0;
            crc_err_q   <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            di_q        <= di_d;
            wcl_q       <= wcl_d;
            wch_q       <= wch_d;
            byte_cnt_q  <= byte_cnt_d;
            crc_q       <= crc_d;
            crc_lo_q    <= crc_lo_d;
            crc_idx_q   <= crc_idx_d;
            research_q  <= research_d;
            fs_q        <= fs_d;
            fe_q        <= fe_d;
            ls_q        <= ls_d;
            le_q        <= le_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
            dt_q        <= dt_d;
            vc_q        <= vc_d;
            wc_q        <= wc_d;
            done_q      <= done_d;
            ecc_err_q   <= ecc_err_d;
            crc_err_q   <= crc_err_d;
            abort_q     <= abort_d;
        end
    end

    assign O_ReSearch_Offset = research_q;
    assign O_Frame_Start     = fs_q;
    assign O_Frame_End       = fe_q;
    assign O_Line_Start      = ls_q;
    assign O_Line_End        = le_q;
    assign O_Pix_Data        = pix_data_q;
    assign O_Pix_Valid       = pix_valid_q;
    assign O_Data_Type       = dt_q;
    assign O_VC              = vc_q;
    assign O_Word_Count      = wc_q;
    assign O_Pkt_Done        = done_q;
    assign O_Ecc_Err         = ecc_err_q;
    assign O_Crc_Err         = crc_err_q;
    assign O_Abort           = abort_q;

endmodule

// File: tb/tb_mipi_csi_packet_parser.sv
// Directed bench for mipi_csi_packet_parser: header/sync, long packets with
// good and bad CRC, ECC error, loss of lock, oversize WC, empty payload and
// asynchronous reset. Payload bytes are checked through a scoreboard queue.
module tb_mipi_csi_packet_parser;

    logic        I_CLK = 1'b0;
    logic        I_Rst_n;
    logic [7:0]  I_Byte_Data;
    logic        I_Byte_Valid;
    logic        O_ReSearch_Offset, O_Frame_Start, O_Frame_End, O_Line_Start, O_Line_End;
    logic [7:0]  O_Pix_Data;
    logic        O_Pix_Valid;
    logic [5:0]  O_Data_Type;
    logic [1:0]  O_VC;
    logic [15:0] O_Word_Count;
    logic        O_Pkt_Done, O_Ecc_Err, O_Crc_Err, O_Abort;

    mipi_csi_packet_parser dut (
        .I_CLK             (I_CLK),
        .I_Rst_n           (I_Rst_n),
        .I_Byte_Data       (I_Byte_Data),
        .I_Byte_Valid      (I_Byte_Valid),
        .O_ReSearch_Offset (O_ReSearch_Offset),
        .O_Frame_Start     (O_Frame_Start),
        .O_Frame_End       (O_Frame_End),
        .O_Line_Start      (O_Line_Start),
        .O_Line_End        (O_Line_End),
        .O_Pix_Data        (O_Pix_Data),
        .O_Pix_Valid       (O_Pix_Valid),
        .O_Data_Type       (O_Data_Type),
        .O_VC              (O_VC),
        .O_Word_Count      (O_Word_Count),
        .O_Pkt_Done        (O_Pkt_Done),
        .O_Ecc_Err         (O_Ecc_Err),
        .O_Crc_Err         (O_Crc_Err),
        .O_Abort           (O_Abort)
    );

    always #5 I_CLK = ~I_CLK;

    // Syndrome column of each header bit D0..D23 (bit k = parity Pk)
    localparam logic [5:0] ECC_COL [24] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19, 6'h1A, 6'h1C, 6'h23, 6'h25,
        6'h26, 6'h29, 6'h2A, 6'h2C, 6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
    };

    int tests = 0;
    int fails = 0;
    int n_fs, n_fe, n_ls, n_le, n_pix, n_done, n_crc, n_ecc, n_abort;
    logic [7:0]  pix_q [$];
    logic [15:0] tb_crc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] ecc_model(input logic [23:0] d);
        logic [5:0] e = 6'd0;
        for (int i = 0; i < 24; i++) if (d[i]) e = e ^ ECC_COL[i];
        return e;
    endfunction

    // Bit-serial LFSR form of the reflected CRC
    task automatic crc_upd(input logic [7:0] b);
        logic fb;
        for (int i = 0; i < 8; i++) begin
            fb     = tb_crc[0] ^ b[i];
            tb_crc = tb_crc >> 1;
            if (fb) tb_crc = tb_crc ^ 16'h8408;
        end
    endtask

    // Monitor runs on the falling edge; the main sequence samples 1 ns later
    always @(negedge I_CLK) begin
        if (I_Rst_n) begin
            n_fs    += int'(O_Frame_Start);
            n_fe    += int'(O_Frame_End);
            n_ls    += int'(O_Line_Start);
            n_le    += int'(O_Line_End);
            n_done  += int'(O_Pkt_Done);
            n_crc   += int'(O_Crc_Err);
            n_ecc   += int'(O_Ecc_Err);
            n_abort += int'(O_Abort);
            if (O_Pix_Valid) begin
                n_pix++;
                tests++;
                assert (pix_q.size() != 0) else begin
                    fails++;
                    $error("FAIL pix_unexpected: got %0h expected none", O_Pix_Data);
                end
                if (pix_q.size() != 0) check("pix_data", 32'(O_Pix_Data), 32'(pix_q.pop_front()));
            end
        end
    end

    task automatic clear_counts();
        n_fs = 0; n_fe = 0; n_ls = 0; n_le = 0; n_pix = 0;
        n_done = 0; n_crc = 0; n_ecc = 0; n_abort = 0;
    endtask

    task automatic step(input logic v, input logic [7:0] b);
        I_Byte_Valid = v;
        I_Byte_Data  = b;
        @(negedge I_CLK);
        #1;
    endtask

    task automatic send_hdr(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] ecc_x);
        tb_crc = 16'hFFFF;
        step(1'b1, 8'hB8);
        step(1'b1, di);
        step(1'b1, wc[7:0]);
        step(1'b1, wc[15:8]);
        step(1'b1, {2'b00, ecc_model({wc, di})} ^ ecc_x);
    endtask

    task automatic send_payload(input int n, input logic [7:0] first, input logic [7:0] inc);
        logic [7:0] b = first;
        for (int i = 0; i < n; i++) begin
            pix_q.push_back(b);
            crc_upd(b);
            step(1'b1, b);
            b = b + inc;
        end
    endtask

    task automatic send_crc(input logic [15:0] x);
        logic [15:0] c = tb_crc ^ x;
        step(1'b1, c[7:0]);
        step(1'b1, c[15:8]);
    endtask

    function automatic logic [9:0] flags();
        return {O_ReSearch_Offset, O_Frame_Start, O_Frame_End, O_Line_Start, O_Line_End,
                O_Pix_Valid, O_Pkt_Done, O_Ecc_Err, O_Crc_Err, O_Abort};
    endfunction

    initial begin
        clear_counts();
        I_Rst_n = 1'b0; I_Byte_Valid = 1'b0; I_Byte_Data = 8'h00;
        repeat (2) @(negedge I_CLK);
        #1;
        check("reset_flags", 32'(flags()), 32'd0);
        check("reset_fields", {O_Pix_Data, O_Data_Type, O_VC, O_Word_Count}, 32'd0);
        I_Rst_n = 1'b1;
        step(1'b0, 8'h00);
        step(1'b1, 8'h55);  // non-SoT byte ignored in idle

        // Frame start
        clear_counts();
        send_hdr(8'h00, 16'h0000, 8'h00);
        check("fs_pulse", 32'(O_Frame_Start), 32'd1);
        check("fs_vc_wc", {14'd0, O_VC, O_Word_Count}, 32'd0);
        check("fs_research_rise", 32'(O_ReSearch_Offset), 32'd1);
        step(1'b1, 8'hB8);
        check("fs_pulse_width", 32'(O_Frame_Start), 32'd0);
        check("fs_research_held", 32'(O_ReSearch_Offset), 32'd1);
        step(1'b0, 8'h00);
        check("fs_research_fall", 32'(O_ReSearch_Offset), 32'd0);
        check("fs_count", 32'(n_fs + n_fe + n_ls + n_le), 32'd1);

        // RAW8 long packet, good CRC
        clear_counts();
        send_hdr(8'h2A, 16'd4, 8'h00);
        check("raw8_dt", 32'(O_Data_Type), 32'h2A);
        check("raw8_wc", 32'(O_Word_Count), 32'd4);
        send_payload(4, 8'h11, 8'h11);
        send_crc(16'h0000);
        check("raw8_done", 32'(O_Pkt_Done), 32'd1);
        check("raw8_crc_err", 32'(O_Crc_Err), 32'd0);
        step(1'b0, 8'h00);
        check("raw8_done_width", 32'(O_Pkt_Done), 32'd0);
        check("raw8_pix_count", 32'(n_pix), 32'd4);

        // Same packet, CRC LSB flipped
        clear_counts();
        send_hdr(8'h2A, 16'd4, 8'h00);
        send_payload(4, 8'h11, 8'h11);
        send_crc(16'h0001);
        check("badcrc_flags", {O_Pkt_Done, O_Crc_Err}, 32'd3);
        step(1'b0, 8'h00);
        check("badcrc_pix_count", 32'(n_pix), 32'd4);

        // FE with ECC bit0 flipped
        clear_counts();
        send_hdr(8'h01, 16'h0000, 8'h01);
        check("ecc_err", 32'(O_Ecc_Err), 32'd1);
        check("ecc_research", 32'(O_ReSearch_Offset), 32'd1);
        step(1'b1, 8'h00);
        check("ecc_err_width", 32'(O_Ecc_Err), 32'd0);
        check("ecc_no_fe", 32'(n_fe), 32'd0);
        step(1'b0, 8'h00);

        // Line start on VC1 with short data field
        clear_counts();
        send_hdr(8'h42, 16'h1234, 8'h00);
        check("ls_pulse", 32'(O_Line_Start), 32'd1);
        check("ls_fields", {6'd0, O_Data_Type, O_VC, O_Word_Count}, {6'd0, 6'h02, 2'd1, 16'h1234});
        step(1'b0, 8'h00);

        // Lock lost after 10 of 100 payload bytes
        clear_counts();
        send_hdr(8'h2B, 16'd100, 8'h00);
        send_payload(10, 8'h01, 8'h03);
        step(1'b0, 8'h00);
        check("drop_abort", {O_Abort, O_Pix_Valid, O_ReSearch_Offset}, 32'b101);
        step(1'b0, 8'h00);
        check("drop_after", {O_Abort, O_ReSearch_Offset}, 32'd0);
        check("drop_counts", {n_pix[15:0], n_done[15:0]}, {16'd10, 16'd0});

        // Oversize word count
        clear_counts();
        send_hdr(8'h2A, 16'd4097, 8'h00);
        check("maxwc_abort", 32'(O_Abort), 32'd1);
        step(1'b0, 8'h00);
        check("maxwc_pix", 32'(n_pix), 32'd0);

        // Empty long packet: CRC bytes follow the header directly
        clear_counts();
        send_hdr(8'h2A, 16'd0, 8'h00);
        send_crc(16'h0000);
        check("wc0_flags", {O_Pkt_Done, O_Crc_Err}, 32'b10);
        step(1'b0, 8'h00);

        // Asynchronous reset mid-payload
        clear_counts();
        send_hdr(8'h2A, 16'd8, 8'h00);
        send_payload(3, 8'hA0, 8'h01);
        check("rst_pre_pix", 32'(O_Pix_Valid), 32'd1);
        #1 I_Rst_n = 1'b0;
        #1;
        check("rst_async_flags", 32'(flags()), 32'd0);
        @(negedge I_CLK);
        #1;
        check("rst_fields", {O_Pix_Data, O_Data_Type, O_VC, O_Word_Count}, 32'd0);
        I_Rst_n = 1'b1;
        step(1'b0, 8'h00);
        clear_counts();
        send_hdr(8'h03, 16'h0000, 8'h00);
        check("rst_then_le", 32'(O_Line_End), 32'd1);
        step(1'b0, 8'h00);
        check("queue_empty", 32'(pix_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
